sb_serializer: RTL and testbench
================================

Name: sb_serializer

Overview:
- Sideband transmit stage; sits directly upstream of the sideband deserializer.
- Accepts one WIDTH-bit parallel word per valid/ready handshake and shifts it out one bit per clk, LSB first.
- Drives a clock-enable that the PHY uses to gate the forwarded sideband clock.
- Drives data on posedge clk, so the deserializer's negedge sampling sees stable, mid-bit data.

Parameters:
- WIDTH, 128, bits per serialized word; must be >= 2.
- WIDTH_W, $clog2(WIDTH), bit-counter width.
- GAP, 32, idle clk cycles between words (used only with SB_SER_GAP_EN); must be >= 1.

Ports:
- clk  input  1  sideband clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to send; bit 0 goes out first.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  1  serial bit to the deserializer.
- out_clk_en  output  1  high for every cycle carrying a valid serial bit.
- tx_done  output  1  one-cycle pulse during the final bit of a word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0, out_data=0, out_clk_en=0, tx_done=0, busy=0.
- in_ready=1 during reset-release IDLE.
- States: IDLE, SHIFT, GAP (GAP exists only with SB_SER_GAP_EN).
- IDLE: in_ready=1. On in_valid&&in_ready at posedge T:
  - shift_reg<=in_data, bit_cnt<=0, state<=SHIFT.
  - From cycle T+1: out_data=in_data[0], out_clk_en=1.
  - Latency from accepting edge to first bit = 1 cycle.
- SHIFT:
  - Each posedge: shift_reg>>=1, bit_cnt+=1.
  - out_data is always shift_reg[0] (registered, glitch-free); out_clk_en=1.
  - Exactly WIDTH cycles with out_clk_en=1 per word; bit_cnt counts 0..WIDTH-1 and never wraps past WIDTH-1.
  - tx_done=1 only while bit_cnt==WIDTH-1.
  - in_ready=0 while bit_cnt<WIDTH-1.
- Last bit (bit_cnt==WIDTH-1): see Optional Feature.
- Idle outputs: out_data=0 and out_clk_en=0 whenever not in SHIFT.
- Input capture: in_data is sampled only on the accepting edge; later changes are ignored.
- in_valid behaviour: in_valid may drop without acceptance; no word is lost or duplicated.
- Reset mid-word or mid-gap:
  - Immediate abort to IDLE with all reset values.
  - Partial word is discarded, not resumed.
  - Downstream re-aligns via its own reset.
- Simultaneous in_valid and rst: rst wins; nothing accepted.

Optional Feature:
- Macro: SB_SER_GAP_EN.
- Defined:
  - At bit_cnt==WIDTH-1, state<=GAP, gap_cnt<=0, in_ready=0.
  - GAP lasts exactly GAP cycles with out_clk_en=0, then state<=IDLE.
  - Minimum spacing between first bits of consecutive words = WIDTH+GAP+1 cycles.
- Undefined (back-to-back):
  - in_ready=1 during bit_cnt==WIDTH-1.
  - If a word is accepted on that edge, reload shift_reg, bit_cnt<=0, stay in SHIFT; out_clk_en stays high with no bubble (word period = WIDTH cycles).
  - Otherwise go to IDLE.

Decomposition:
- Shared package sb_pkg holds:
  - SB_WIDTH=128 and SB_GAP=32 constants.
  - sb_ser_state_t enum {IDLE, SHIFT, GAP}.
- Deserializer and serializer both take SB_WIDTH from sb_pkg.
- No sub-module; a single FSM plus shift register and counters.

Test Plan:
- Single word: reset, send 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → 128 out_clk_en cycles, first bit 0 (LSB), tx_done exactly on cycle 128, a looped-back deserializer reads the identical word.
- Back-to-back, macro undefined: in_valid held with words A=all-ones then B=128'h5 → out_clk_en high for 256 contiguous cycles, no bubble, B bits start the cycle after A's last bit.
- Gap, macro defined: same two words → exactly 32 cycles with out_clk_en=0 and in_ready=0 between words, then in_ready=1 for one IDLE cycle before B starts.
- Mid-word reset: assert rst at bit 60 → out_clk_en=0, busy=0, in_ready=1 next cycle; the next word sends from bit 0 intact.
- Input stability: change in_data every cycle during SHIFT → serial stream equals only the value captured at the handshake.
- Stall: in_valid low for 10 cycles in IDLE → out_clk_en stays 0, busy=0, no tx_done.

Source files
------------

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared sideband constants and serializer state type
package sb_pkg;

    localparam int SB_WIDTH = 128;
    localparam int SB_GAP   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_ser_state_t;

endpackage

// File: rtl/sb_serializer.sv
// rtl/sb_serializer.sv - sideband LSB-first serializer; define SB_SER_GAP_EN for an idle gap between words
module sb_serializer
    import sb_pkg::*;
#(
    parameter int WIDTH   = SB_WIDTH,
    parameter int WIDTH_W = $clog2(WIDTH),
    parameter int GAP     = SB_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_clk_en,
    output logic             tx_done,
    output logic             busy
);

    localparam logic [WIDTH_W-1:0] LAST_BIT = WIDTH_W'(WIDTH - 1);

    if (WIDTH < 2 || GAP < 1) begin : g_bad_param
        $error("sb_serializer: WIDTH must be >= 2 and GAP >= 1");
    end

`ifdef SB_SER_GAP_EN
    localparam int             GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    sb_ser_state_t      state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH_W-1:0] bit_cnt_q, bit_cnt_d;
    logic               out_data_q, out_clk_en_q, tx_done_q, busy_q;
    logic               last_bit;
    logic               accept;

    assign last_bit = (state_q == sb_pkg::SHIFT) && (bit_cnt_q == LAST_BIT);
    assign accept   = in_valid && in_ready;

    // Ready in IDLE; without the gap also during the final bit so words can chain
    always_comb begin
        in_ready = 1'b0;
`ifdef SB_SER_GAP_EN
        in_ready = (state_q == sb_pkg::IDLE);
`else
        in_ready = (state_q == sb_pkg::IDLE) || last_bit;
`endif
    end

    // Next-state logic for the FSM, shift register and counters
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SB_SER_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            sb_pkg::IDLE: begin
                if (accept) begin
                    state_d   = sb_pkg::SHIFT;
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                end
            end
            sb_pkg::SHIFT: begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef SB_SER_GAP_EN
                    state_d   = sb_pkg::GAP;
                    gap_cnt_d = '0;
`else
                    if (accept) begin
                        shift_d = in_data;
                    end else begin
                        state_d = sb_pkg::IDLE;
                    end
`endif
                end
            end
            sb_pkg::GAP: begin
`ifdef SB_SER_GAP_EN
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = sb_pkg::IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
`else
                state_d = sb_pkg::IDLE;
`endif
            end
            default: state_d = sb_pkg::IDLE;
        endcase
    end

    // State registers; outputs are registered from next-state so the serial line never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= sb_pkg::IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
`ifdef SB_SER_GAP_EN
            gap_cnt_q    <= '0;
`endif
            out_data_q   <= 1'b0;
            out_clk_en_q <= 1'b0;
            tx_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
`ifdef SB_SER_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
            out_data_q   <= (state_d == sb_pkg::SHIFT) && shift_d[0];
            out_clk_en_q <= (state_d == sb_pkg::SHIFT);
            tx_done_q    <= (state_d == sb_pkg::SHIFT) && (bit_cnt_d == LAST_BIT);
            busy_q       <= (state_d != sb_pkg::IDLE);
        end
    end

    assign out_data   = out_data_q;
    assign out_clk_en = out_clk_en_q;
    assign tx_done    = tx_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sb_serializer.sv
// tb/tb_sb_serializer.sv - scoreboard bench for sb_serializer (honours SB_SER_GAP_EN)
module tb_sb_serializer;
    import sb_pkg::*;

    localparam int W = SB_WIDTH;
    localparam int G = SB_GAP;
`ifdef SB_SER_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, out_data, out_clk_en, tx_done, busy;

    sb_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_clk_en (out_clk_en),
        .tx_done    (tx_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic b;
        logic last;
    } exp_t;

    exp_t         bq[$];
    logic [W-1:0] wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference: the word in flight occupies cycles first_c..last_c on the wire
    bit have_word = 1'b0;
    int first_c   = 0;
    int last_c    = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic bit exp_ready(input int c);
        if (!have_word) return 1'b1;
        return GAP_EN ? (c > last_c + G) : (c >= last_c);
    endfunction

    function automatic bit exp_busy(input int c);
        return have_word && (c <= last_c + (GAP_EN ? G : 0));
    endfunction

    function automatic bit exp_en(input int c);
        return have_word && (c >= first_c) && (c <= last_c);
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // one clock: check control outputs, drive inputs, then record any handshake
    task automatic cycle(input bit v, input logic [W-1:0] d, output bit acc);
        int c;
        bit rdy;
        @(negedge clk);
        c   = cyc;
        rdy = exp_ready(c);
        chk("in_ready", in_ready, rdy);
        chk("busy", busy, exp_busy(c));
        chk("out_clk_en", out_clk_en, exp_en(c));
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = v && rdy && !rst;
        if (acc) begin
            first_c   = c + 1;
            last_c    = c + W;
            have_word = 1'b1;
            for (int k = 0; k < W; k++) begin
                bq.push_back('{cyc: c + 1 + k, b: d[k], last: (k == W - 1)});
            end
            wq.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, rand_word(), acc);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 1000) begin
            cycle(1'b1, d, acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        idle(W + G + 4);
    endtask

    // monitor: pops the expected serial bit whenever the DUT claims a valid bit
    exp_t         e;
    logic [W-1:0] deser = '0;
    logic [W-1:0] w_exp;
    always @(negedge clk) begin
        if (out_clk_en) begin
            if (bq.size() == 0) begin
                chk("unexpected_bit", out_clk_en, 1'b0);
            end else begin
                e = bq.pop_front();
                chk("bit_cycle", cyc, e.cyc);
                chk("bit_data", out_data, e.b);
                chk("tx_done", tx_done, e.last);
                deser = {out_data, deser[W-1:1]};
                if (e.last && wq.size() > 0) begin
                    w_exp = wq.pop_front();
                    chk("loopback_word", deser, w_exp);
                end
            end
        end else begin
            chk("idle_out_data", out_data, 1'b0);
            chk("idle_tx_done", tx_done, 1'b0);
            if (bq.size() > 0 && bq[0].cyc <= cyc) begin
                chk("missing_bit", out_clk_en, 1'b1);
                void'(bq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        // reset state, including a valid that must be ignored while rst is high
        cycle(1'b0, '0, acc);
        cycle(1'b1, rand_word(), acc);
        cycle(1'b0, '0, acc);
        #1 rst = 1'b0;

        // stall in IDLE
        idle(10);

        // single directed word
        send_word(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        drain();

        // back-to-back with valid held
        send_word({W{1'b1}});
        send_word(128'h5);
        drain();

        // input stability: idle cycles drive fresh random data during SHIFT
        send_word(rand_word());
        drain();

        // mid-word reset at bit 60, valid asserted alongside rst
        send_word(rand_word());
        idle(60);
        #1 rst = 1'b1;
        bq.delete();
        wq.delete();
        have_word = 1'b0;
        cycle(1'b1, rand_word(), acc);
        #1 rst = 1'b0;
        send_word(rand_word());
        drain();

        // randomized traffic with random spacing, including chained words
        for (int i = 0; i < 25; i++) begin
            idle($urandom_range(0, 2));
            send_word(rand_word());
        end
        drain();

        chk("bits_outstanding", bq.size(), 0);
        chk("words_outstanding", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
